// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU data port
// and a debug/DMA port. The CPU has priority, but a debug request that has
// waited MAX_WAIT cycles takes the port for one cycle, which bounds debug
// latency while costing the CPU at most one stall per debug access.
// Read data returns one cycle after the grant and is steered back to whichever
// port issued the read. The CPU sees held data otherwise, so debug traffic
// never disturbs it.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4   // 1..15
) (
  input  logic        clk_core,
  input  logic        sys_rst_n,

  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,

  input  logic        dbg_req,
  input  logic [3:0]  dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,

  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {OWN_CPU_RD, OWN_DBG_RD} owner_e;

  req_t       cpu_r, dbg_r, sel_r;
  owner_e     owner, owner_nxt;
  logic       run;          // low until the first edge after reset release
  logic [3:0] wait_cnt;
  logic       rd_pending;
  logic [31:0] cpu_hold;
  logic       cpu_gnt, dbg_win, rd_issue;
  logic       cpu_rd_vld, dbg_rd_vld;

  assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_r = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

  // Per-cycle grant: debug wins when starved or when the CPU is idle.
  always_comb begin
    dbg_win = run & dbg_req & ((wait_cnt == WAIT_LIM) | ~cpu_req);
    cpu_gnt = run & cpu_req & ~dbg_win;
  end

  assign dbg_gnt   = dbg_win;
  // Stall is suppressed while reset is held so the CPU sees a quiet port.
  assign cpu_stall = sys_rst_n & cpu_req & ~cpu_gnt;

  // Memory-side mux from the granted port; no grant means no write strobes.
  always_comb begin
    sel_r     = dbg_win ? dbg_r : cpu_r;
    mem_en    = cpu_gnt | dbg_win;
    mem_we    = mem_en ? sel_r.we : 4'b0000;
    mem_addr  = sel_r.addr;
    mem_wdata = sel_r.wdata;
    rd_issue  = mem_en & (sel_r.we == 4'b0000);
  end

  // Owner next-state: only a granted read changes who owns the return data.
  always_comb begin
    owner_nxt = owner;
    if (rd_issue) owner_nxt = dbg_win ? OWN_DBG_RD : OWN_CPU_RD;
  end

  // Owner register and read-pending flag.
  always_ff @(posedge clk_core or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      owner      <= OWN_CPU_RD;
      rd_pending <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      rd_pending <= rd_issue;
    end
  end

  // Grants are held off until the first edge after reset release.
  always_ff @(posedge clk_core or negedge sys_rst_n) begin
    if (!sys_rst_n) run <= 1'b0;
    else            run <= 1'b1;
  end

  // Debug starvation counter: counts refused cycles, saturates at the limit.
  always_ff @(posedge clk_core or negedge sys_rst_n) begin
    if (!sys_rst_n)                        wait_cnt <= 4'd0;
    else if (!dbg_req || dbg_win)          wait_cnt <= 4'd0;
    else if (run && wait_cnt < WAIT_LIM)   wait_cnt <= wait_cnt + 4'd1;
  end

  assign cpu_rd_vld = rd_pending & (owner == OWN_CPU_RD);
  assign dbg_rd_vld = rd_pending & (owner == OWN_DBG_RD);

  // Keep the last CPU read result so cpu_rdata is stable between CPU reads.
  always_ff @(posedge clk_core or negedge sys_rst_n) begin
    if (!sys_rst_n)      cpu_hold <= 32'd0;
    else if (cpu_rd_vld) cpu_hold <= mem_rdata;
  end

  assign cpu_rdata  = cpu_rd_vld ? mem_rdata : cpu_hold;
  assign dbg_rvalid = dbg_rd_vld;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk_core = 1'b0;
  logic        sys_rst_n;
  logic        cpu_req, dbg_req;
  logic [3:0]  cpu_we, dbg_we, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_en;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk_core(clk_core), .sys_rst_n(sys_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk_core = ~clk_core;

  // Synchronous single-port memory, preloaded on reset.
  always @(posedge clk_core or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h40] <= 32'hDEADBEEF;  // 0x100
      mem[8'h04] <= 32'h11111111;  // 0x10
      mem[8'h08] <= 32'h22222222;  // 0x20
      mem[8'h20] <= 32'h80808080;  // 0x80
      mem_rdata  <= 32'd0;
    end else if (mem_en) begin
      if (|mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Continuous CPU read of 0x10 while debug reads daddr: four CPU grants,
  // then debug on the fifth cycle with a single CPU stall.
  task automatic starve(input logic [31:0] daddr, input logic [31:0] dexp);
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = daddr;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("starve_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("starve_dbg_gnt",   {31'd0, dbg_gnt},   32'd0);
      chk("starve_mem_addr",  mem_addr,           32'h10);
      if (k > 0) chk("starve_cpu_rdata", cpu_rdata, 32'h11111111);
      tick();
    end
    #1;
    chk("starve_dbg_gnt5",   {31'd0, dbg_gnt},   32'd1);
    chk("starve_cpu_stall5", {31'd0, cpu_stall}, 32'd1);
    chk("starve_mem_addr5",  mem_addr,           daddr);
    tick();
    dbg_req = 1'b0;
    #1;
    chk("starve_rvalid",    {31'd0, dbg_rvalid}, 32'd1);
    chk("starve_dbg_rdata", dbg_rdata,           dexp);
    chk("starve_cpu_hold",  cpu_rdata,           32'h11111111);
    chk("starve_no_stall",  {31'd0, cpu_stall},  32'd0);
    tick();
    chk("starve_rvalid_1p", {31'd0, dbg_rvalid}, 32'd0);
    chk("starve_cpu_rd2",   cpu_rdata,           32'h11111111);
    cpu_req = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h100; cpu_wdata = 32'd0;
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h40;  dbg_wdata = 32'h0;
    tick(); tick();
    // Reset state with both requesters active.
    chk("rst_mem_en",   {31'd0, mem_en},     32'd0);
    chk("rst_mem_we",   {28'd0, mem_we},     32'd0);
    chk("rst_stall",    {31'd0, cpu_stall},  32'd0);
    chk("rst_dbg_gnt",  {31'd0, dbg_gnt},    32'd0);
    chk("rst_rvalid",   {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata,          32'd0);

    // Release: no grant before the first edge afterwards.
    dbg_req = 1'b0;
    sys_rst_n = 1'b1;
    #1;
    chk("pre_edge_mem_en", {31'd0, mem_en}, 32'd0);
    cpu_req = 1'b0;
    tick();

    // CPU-only read.
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h100;
    #1;
    chk("cpu_rd_mem_en",   {31'd0, mem_en},    32'd1);
    chk("cpu_rd_stall",    {31'd0, cpu_stall}, 32'd0);
    chk("cpu_rd_mem_addr", mem_addr,           32'h100);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("cpu_rd_data",   cpu_rdata,          32'hDEADBEEF);
    chk("cpu_rd_idle",   {31'd0, mem_en},    32'd0);
    chk("cpu_rd_norv",   {31'd0, dbg_rvalid}, 32'd0);
    tick();
    chk("cpu_rd_hold",   cpu_rdata,          32'hDEADBEEF);

    // Debug-only write.
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h40; dbg_wdata = 32'hA5A5A5A5;
    #1;
    chk("dbg_wr_gnt",   {31'd0, dbg_gnt}, 32'd1);
    chk("dbg_wr_we",    {28'd0, mem_we},  32'hF);
    chk("dbg_wr_wdata", mem_wdata,        32'hA5A5A5A5);
    tick();
    // Back-to-back debug request is granted again at once.
    dbg_addr = 32'h44; dbg_wdata = 32'h5A5A5A5A;
    #1;
    chk("dbg_b2b_gnt",  {31'd0, dbg_gnt},    32'd1);
    chk("dbg_wr_norv",  {31'd0, dbg_rvalid}, 32'd0);
    chk("dbg_wr_mem",   mem[8'h10],          32'hA5A5A5A5);
    tick();
    dbg_req = 1'b0;
    chk("dbg_b2b_mem",  mem[8'h11],          32'h5A5A5A5A);
    chk("dbg_b2b_norv", {31'd0, dbg_rvalid}, 32'd0);
    chk("dbg_wr_cpu",   cpu_rdata,           32'hDEADBEEF);
    tick();

    // Starvation bound, then again starting from a cleared counter.
    starve(32'h80, 32'h80808080);
    tick();
    starve(32'h20, 32'h22222222);
    tick();

    // CPU byte write passes data unmodified and does not touch cpu_rdata.
    cpu_req = 1'b1; cpu_we = 4'b0010; cpu_addr = 32'h8; cpu_wdata = 32'h12345678;
    #1;
    chk("byte_we",    {28'd0, mem_we}, 32'h2);
    chk("byte_wdata", mem_wdata,       32'h12345678);
    tick();
    cpu_req = 1'b0; cpu_we = 4'h0;
    chk("byte_mem",   mem[8'h02],      32'h00005600);
    chk("byte_cpu_rd", cpu_rdata,      32'h11111111);
    tick();

    // Reset right after a granted debug read drops the response.
    dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h20;
    #1;
    chk("rstrd_gnt", {31'd0, dbg_gnt}, 32'd1);
    tick();
    dbg_req = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("rstrd_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rstrd_mem_en", {31'd0, mem_en},     32'd0);
    chk("rstrd_cpu",    cpu_rdata,           32'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rstrd_post_rv", {31'd0, dbg_rvalid}, 32'd0);
    tick();
    chk("rstrd_post_rv2", {31'd0, dbg_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 4, debug-port starvation limit in cycles; legal range 1..15.
REQ-002 clk_core  input  1  core clock; all state SHALL update on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cpu_req  input  1  CPU data access request this cycle.
REQ-005 cpu_we  input  4  CPU byte write enables; 4'b0000 means read.
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_rdata  output  32  CPU read data, valid one cycle after a granted CPU read.
REQ-009 cpu_stall  output  1  CPU request not granted this cycle; CPU holds its request.
REQ-010 dbg_req  input  1  debug/DMA access request; held until granted.
REQ-011 dbg_we  input  4  debug byte write enables; 4'b0000 means read.
REQ-012 dbg_addr  input  32  debug byte address.
REQ-013 dbg_wdata  input  32  debug write data.
REQ-014 dbg_gnt  output  1  one-cycle pulse: debug request accepted this cycle.
REQ-015 dbg_rvalid  output  1  one-cycle pulse: dbg_rdata valid, cycle after a granted debug read.
REQ-016 dbg_rdata  output  32  debug read data.
REQ-017 mem_en  output  1  single-port DATA_MEM enable.
REQ-018 mem_we  output  4  DATA_MEM byte write enables.
REQ-019 mem_addr  output  32  DATA_MEM address.
REQ-020 mem_wdata  output  32  DATA_MEM write data.
REQ-021 mem_rdata  input  32  DATA_MEM read data, one-cycle synchronous read latency.

Function
REQ-022 Grant SHALL be combinational per cycle: debug wins if dbg_req and wait_cnt == MAX_WAIT, or if dbg_req and not cpu_req; otherwise CPU wins if cpu_req.
REQ-023 mem_en = (cpu_gnt | dbg_gnt); mem_we/addr/wdata SHALL mux from the granted port; with no grant, mem_we SHALL be 4'b0000.
REQ-024 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-025 wait_cnt (4-bit) SHALL increment when dbg_req & ~dbg_gnt, saturate at MAX_WAIT, and clear when dbg_gnt or ~dbg_req.
REQ-026 A 2-state owner register {OWN_CPU_RD, OWN_DBG_RD} plus rd_pending flag SHALL record which port issued a read last cycle; writes SHALL NOT set rd_pending.
REQ-027 dbg_rvalid SHALL assert exactly one cycle after a granted debug read; dbg_rdata = mem_rdata that cycle.
REQ-028 cpu_hold (32-bit register) SHALL capture mem_rdata in the cycle after a granted CPU read.
REQ-029 cpu_rdata SHALL be mem_rdata in the cycle after a granted CPU read, otherwise cpu_hold, so debug traffic never corrupts CPU read data.
REQ-030 Debug SHALL never wait more than MAX_WAIT+1 cycles under continuous CPU load; CPU SHALL lose at most one cycle per debug grant.
REQ-031 Simultaneous requests with wait_cnt < MAX_WAIT: CPU granted, wait_cnt increments.
REQ-032 Back-to-back debug requests: second request is arbitrated afresh with wait_cnt = 0.

Reset
REQ-033 While sys_rst_n = 0: wait_cnt = 0, rd_pending = 0, owner = OWN_CPU_RD, cpu_hold = 0, dbg_gnt = 0, dbg_rvalid = 0, mem_en = 0, mem_we = 4'b0000, cpu_stall = 0.
REQ-034 Reset asserted mid-read SHALL drop the pending dbg_rvalid; no response is issued after release.
REQ-035 First grant SHALL occur no earlier than the first rising edge after sys_rst_n deasserts.

Verification
REQ-036 CPU only: read 0x100 (mem holds 0xDEADBEEF) -> mem_en=1 same cycle, cpu_rdata=0xDEADBEEF next cycle, cpu_stall never 1.
REQ-037 Debug only: write 0xA5A5A5A5 to 0x40, we=4'hF -> dbg_gnt pulse same cycle, mem_we=4'hF, no dbg_rvalid.
REQ-038 Continuous cpu_req + dbg read at 0x80, MAX_WAIT=4 -> CPU granted 4 cycles, debug granted on 5th, cpu_stall=1 that cycle only, dbg_rvalid next cycle.
REQ-039 CPU read 0x10 (0x11111111), then debug read 0x20 (0x22222222) while CPU stalled -> cpu_rdata stays 0x11111111, dbg_rdata=0x22222222.
REQ-040 Byte write cpu_we=4'b0010 to 0x8 -> mem_we=4'b0010, mem_wdata=cpu_wdata unmodified.
REQ-041 sys_rst_n low in cycle after granted debug read -> dbg_rvalid stays 0, wait_cnt=0, all outputs at REQ-033 values.
